// File: rtl/phased_signal_controller_pkg.sv
// Shared types, lamp encodings and the round-robin phase picker for the
// phased signal controller.
package signal_ctrl_pkg;

    localparam int MAX_PHASES = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_PED     = 3'd1,
        ST_ALLRED  = 3'd2,
        ST_GREEN   = 3'd3,
        ST_YELLOW  = 3'd4
    } state_t;

    localparam logic [2:0] LIGHT_R = 3'b001;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b100;

    function automatic int ph_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Nearest requester after 'last' (wrapping, 'last' itself checked last);
    // with no requester anywhere, plain rotation to last+1.
    function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_PHASES-1:0] req,
                                                 input logic [IDX_W-1:0]      last,
                                                 input int                    n);
        int pick;
        int idx;
        pick = (int'(last) + 1) % n;
        for (int i = MAX_PHASES; i >= 1; i--) begin
            idx = (int'(last) + i) % n;
            if (i <= n && req[idx[IDX_W-1:0]]) pick = idx;
        end
        return IDX_W'(pick);
    endfunction

endpackage

// File: rtl/phased_signal_controller_if.sv
// Sensor/lamp-side bundle of the signal controller; master drives the
// request and tick inputs, slave is the controller itself.
interface phased_signal_controller_if #(parameter int NUM_PHASES = 2) ();
    import signal_ctrl_pkg::*;

    localparam int PH_W = ph_width(NUM_PHASES);

    logic                    tick;
    logic [NUM_PHASES-1:0]   car_req;
    logic                    ped_req;
    logic [3*NUM_PHASES-1:0] light;
    logic [NUM_PHASES-1:0]   ped_walk;
    logic                    ped_all;
    logic [PH_W-1:0]         phase_idx;
    logic                    ped_pend;

    modport master (
        output tick, car_req, ped_req,
        input  light, ped_walk, ped_all, phase_idx, ped_pend
    );

    modport slave (
        input  tick, car_req, ped_req,
        output light, ped_walk, ped_all, phase_idx, ped_pend
    );

endinterface

// File: rtl/phased_signal_controller_counter.sv
// Loadable down-counter that only moves on tick; expire flags the tick that
// ends a D-tick interval.
module tick_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && r_count > CNT_W'(1)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count  = r_count;
    assign expire = tick && (r_count == CNT_W'(1));

endmodule

// File: rtl/phased_signal_controller.sv
// N-approach signal controller: round-robin greens, latched scramble walk,
// all-red clearance; all lamp outputs registered.
module phased_signal_controller
    import signal_ctrl_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 4,
    parameter int GREEN_T    = 10,
    parameter int YELLOW_T   = 5,
    parameter int ALLRED_T   = 1,
    parameter int PED_T      = 15
) (
    input logic                       clk,
    input logic                       rst,
    phased_signal_controller_if.slave bus
);

    localparam int PH_W = ph_width(NUM_PHASES);

    state_t                  r_state;
    logic [PH_W-1:0]         r_phase_idx;
    logic                    r_ped_pend;
    logic [3*NUM_PHASES-1:0] r_light;
    logic [NUM_PHASES-1:0]   r_walk;
    logic                    r_ped_all;

    state_t                  w_next_state;
    logic [PH_W-1:0]         w_next_phase;
    logic                    w_load;
    logic [CNT_W-1:0]        w_load_val;
    logic [CNT_W-1:0]        w_count;
    logic                    w_expire;
    logic                    w_done;
    logic [IDX_W-1:0]        w_rr;
    logic                    w_ped_enter;
    logic [3*NUM_PHASES-1:0] w_light;
    logic [NUM_PHASES-1:0]   w_walk;
    logic                    w_ped_all;

    tick_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (bus.tick),
        .count    (w_count),
        .expire   (w_expire)
    );

    // A zero count inside a timed state means a corrupted counter; ending the
    // interval on the next tick keeps the sequence from stalling.
    assign w_done = w_expire || (bus.tick && w_count == '0);
    assign w_rr   = rr_next(MAX_PHASES'(bus.car_req), IDX_W'(r_phase_idx), NUM_PHASES);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase_idx;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            ST_STARTUP: begin
                w_next_state = ST_PED;
                w_load       = 1'b1;
                w_load_val   = CNT_W'(PED_T);
            end
            ST_PED: if (w_done) begin
                w_next_state = ST_ALLRED;
                w_load       = 1'b1;
                w_load_val   = CNT_W'(ALLRED_T);
            end
            ST_ALLRED: if (w_done) begin
                w_next_state = ST_GREEN;
                w_next_phase = PH_W'(w_rr);
                w_load       = 1'b1;
                w_load_val   = CNT_W'(GREEN_T);
            end
            ST_GREEN: if (w_done) begin
                w_next_state = ST_YELLOW;
                w_load       = 1'b1;
                w_load_val   = CNT_W'(YELLOW_T);
            end
            ST_YELLOW: if (w_done) begin
                w_load = 1'b1;
                if (r_ped_pend || bus.ped_req) begin
                    w_next_state = ST_PED;
                    w_load_val   = CNT_W'(PED_T);
                end else begin
                    w_next_state = ST_ALLRED;
                    w_load_val   = CNT_W'(ALLRED_T);
                end
            end
            default: w_next_state = ST_STARTUP;
        endcase
    end

    assign w_ped_enter = (w_next_state == ST_PED) && (r_state != ST_PED);

    // Lamps are decoded from the upcoming state so they change on the same
    // edge as the state register.
    always_comb begin
        w_light   = {NUM_PHASES{LIGHT_R}};
        w_walk    = '0;
        w_ped_all = 1'b0;
        case (w_next_state)
            ST_PED: begin
                w_walk    = '1;
                w_ped_all = 1'b1;
            end
            ST_GREEN: begin
                for (int p = 0; p < NUM_PHASES; p++) begin
                    if (PH_W'(p) == w_next_phase) begin
                        w_light[3*p +: 3] = LIGHT_G;
                        w_walk[p]         = 1'b1;
                    end
                end
            end
            ST_YELLOW: begin
                for (int p = 0; p < NUM_PHASES; p++) begin
                    if (PH_W'(p) == w_next_phase) w_light[3*p +: 3] = LIGHT_Y;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STARTUP;
            r_phase_idx <= PH_W'(NUM_PHASES - 1);
            r_ped_pend  <= 1'b0;
            r_light     <= {NUM_PHASES{LIGHT_R}};
            r_walk      <= '0;
            r_ped_all   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_phase_idx <= w_next_phase;
            r_light     <= w_light;
            r_walk      <= w_walk;
            r_ped_all   <= w_ped_all;
            if (w_ped_enter) begin
                r_ped_pend <= 1'b0;
            end else if (bus.ped_req && r_state != ST_PED) begin
                r_ped_pend <= 1'b1;
            end
        end
    end

    assign bus.light     = r_light;
    assign bus.ped_walk  = r_walk;
    assign bus.ped_all   = r_ped_all;
    assign bus.phase_idx = r_phase_idx;
    assign bus.ped_pend  = r_ped_pend;

endmodule

// File: tb/tb_phased_signal_controller.sv
// Bench for the signal controller: a 2-phase and a 4-phase instance checked
// every cycle against a ticks-remaining model plus pinned timeline values.
module tb_phased_signal_controller;
    import signal_ctrl_pkg::*;

    localparam int G_T  = 3;
    localparam int Y_T  = 2;
    localparam int AR_T = 1;
    localparam int P_T  = 4;

    localparam int M_STARTUP = 0;
    localparam int M_PED     = 1;
    localparam int M_ALLRED  = 2;
    localparam int M_GREEN   = 3;
    localparam int M_YELLOW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b1;
    int   tick_div = 1;
    int   tick_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    phased_signal_controller_if #(.NUM_PHASES(2)) bus_a ();
    phased_signal_controller_if #(.NUM_PHASES(4)) bus_b ();

    assign bus_a.tick = tick;
    assign bus_b.tick = tick;

    phased_signal_controller #(
        .NUM_PHASES(2), .CNT_W(4), .GREEN_T(G_T), .YELLOW_T(Y_T), .ALLRED_T(AR_T), .PED_T(P_T)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    phased_signal_controller #(
        .NUM_PHASES(4), .CNT_W(4), .GREEN_T(G_T), .YELLOW_T(Y_T), .ALLRED_T(AR_T), .PED_T(P_T)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            tick = (tick_cnt % tick_div) == 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: which phase each instance is in and how many ticks remain.
    int m_n[2] = '{2, 4};
    int m_st[2];
    int m_left[2];
    int m_ph[2];
    bit m_pend[2];

    task automatic m_reset(input int id);
        m_st[id]   = M_STARTUP;
        m_left[id] = 0;
        m_ph[id]   = m_n[id] - 1;
        m_pend[id] = 1'b0;
    endtask

    // Requester at the smallest forward distance from the last green wins;
    // the last green itself is at distance n.
    function automatic int m_pick(input int id, input logic [7:0] req);
        int best, bestd, d, n;
        n = m_n[id];
        best = -1;
        bestd = n + 1;
        for (int q = 0; q < n; q++) begin
            d = ((q - m_ph[id] + n - 1) % n) + 1;
            if (req[q] && d < bestd) begin
                best = q;
                bestd = d;
            end
        end
        if (best < 0) best = (m_ph[id] + 1) % n;
        return best;
    endfunction

    task automatic m_step(input int id, input logic t, input logic [7:0] req, input logic ped);
        int st, nx;
        st = m_st[id];
        nx = st;
        if (st == M_STARTUP) begin
            nx = M_PED;
            m_left[id] = P_T;
        end else if (t) begin
            if (m_left[id] > 1) begin
                m_left[id]--;
            end else begin
                case (st)
                    M_PED:    begin nx = M_ALLRED; m_left[id] = AR_T; end
                    M_ALLRED: begin nx = M_GREEN; m_left[id] = G_T; m_ph[id] = m_pick(id, req); end
                    M_GREEN:  begin nx = M_YELLOW; m_left[id] = Y_T; end
                    default: begin
                        if (m_pend[id] || ped) begin nx = M_PED; m_left[id] = P_T; end
                        else begin nx = M_ALLRED; m_left[id] = AR_T; end
                    end
                endcase
            end
        end
        if (nx == M_PED && st != M_PED) m_pend[id] = 1'b0;
        else if (ped && st != M_PED) m_pend[id] = 1'b1;
        m_st[id] = nx;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset(0);
                m_reset(1);
            end else begin
                m_step(0, tick, 8'(bus_a.car_req), bus_a.ped_req);
                m_step(1, tick, 8'(bus_b.car_req), bus_b.ped_req);
            end
        end
    end

    task automatic cmp(input int id, input string pfx, input logic [11:0] light,
                       input logic [3:0] walk, input logic pa, input logic [2:0] ph, input logic pp);
        int n, nonred;
        logic [11:0] el;
        logic [3:0] ew;
        n = m_n[id];
        el = '0;
        ew = '0;
        nonred = 0;
        for (int p = 0; p < n; p++) el[3*p +: 3] = LIGHT_R;
        case (m_st[id])
            M_PED:    ew = 4'((1 << n) - 1);
            M_GREEN:  begin el[3*m_ph[id] +: 3] = LIGHT_G; ew[m_ph[id]] = 1'b1; end
            M_YELLOW: el[3*m_ph[id] +: 3] = LIGHT_Y;
            default: ;
        endcase
        check({pfx, "_light"}, 32'(light), 32'(el));
        check({pfx, "_walk"}, 32'(walk), 32'(ew));
        check({pfx, "_ped_all"}, 32'(pa), 32'(m_st[id] == M_PED));
        check({pfx, "_phase_idx"}, 32'(ph), 32'(m_ph[id]));
        check({pfx, "_ped_pend"}, 32'(pp), 32'(m_pend[id]));
        for (int p = 0; p < n; p++) if (light[3*p +: 3] != LIGHT_R) nonred++;
        checks++;
        assert (nonred <= 1) else begin
            errors++;
            $display("FAIL %s_safety: %0d approaches non-red, at most 1 allowed", pfx, nonred);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, "a", 12'(bus_a.light), 4'(bus_a.ped_walk), bus_a.ped_all, 3'(bus_a.phase_idx), bus_a.ped_pend);
        cmp(1, "b", 12'(bus_b.light), bus_b.ped_walk, bus_b.ped_all, 3'(bus_b.phase_idx), bus_b.ped_pend);
    end

    task automatic step_n(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit a_cond(input int what);
        case (what)
            0:       return bus_a.light[2:0] == LIGHT_G;
            1:       return bus_a.light[2:0] != LIGHT_G;
            2:       return bus_a.light[2:0] == LIGHT_Y;
            default: return bus_a.ped_all == 1'b1;
        endcase
    endfunction

    task automatic wait_a(input int what, input int limit, input string name);
        int k;
        k = 0;
        while (!a_cond(what) && k < limit) begin
            step_n(1);
            k++;
        end
        check({name, "_in_time"}, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int g0_cnt;
        bit p1_seen;
        int n_green;

        bus_a.car_req = '0;
        bus_a.ped_req = 1'b0;
        bus_b.car_req = 4'b0010;
        bus_b.ped_req = 1'b0;

        step_n(3);
        check("rst_a_light", 32'(bus_a.light), 32'h09);
        check("rst_b_light", 32'(bus_b.light), 32'h249);
        check("rst_a_phase", 32'(bus_a.phase_idx), 32'd1);
        check("rst_b_phase", 32'(bus_b.phase_idx), 32'd3);
        check("rst_a_ped_all", 32'(bus_a.ped_all), 32'd0);

        @(negedge clk) rst = 1'b0;
        step_n(1);
        check("e1_a_ped_all", 32'(bus_a.ped_all), 32'd1);
        check("e1_a_walk", 32'(bus_a.ped_walk), 32'h3);
        step_n(4);
        check("e5_a_allred", 32'(bus_a.light), 32'h09);
        check("e5_a_ped_all", 32'(bus_a.ped_all), 32'd0);
        step_n(1);
        check("e6_a_green0", 32'(bus_a.light), 32'h0c);
        check("e6_b_phase", 32'(bus_b.phase_idx), 32'd1);
        bus_b.car_req = 4'b1001;
        step_n(3);
        check("e9_a_yellow0", 32'(bus_a.light), 32'h0a);
        step_n(3);
        check("e12_a_green1", 32'(bus_a.light), 32'h21);
        check("e12_b_green3", 32'(bus_b.light), 32'h849);
        step_n(6);
        check("e18_a_phase", 32'(bus_a.phase_idx), 32'd0);
        check("e18_b_phase", 32'(bus_b.phase_idx), 32'd0);

        // Sole requester p0 is re-served every round.
        bus_a.car_req = 2'b01;
        g0_cnt = 0;
        p1_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_n(1);
            if (bus_a.light[5:3] != LIGHT_R) p1_seen = 1'b1;
            if (bus_a.light[2:0] == LIGHT_G) g0_cnt++;
        end
        check("hold_p1_never_green", 32'(p1_seen), 32'd0);
        check("hold_p0_green_cycles", 32'(g0_cnt), 32'd15);

        // Pedestrian pulse during green p0.
        wait_a(0, 50, "ped_wait_green");
        bus_a.ped_req = 1'b1;
        step_n(1);
        bus_a.ped_req = 1'b0;
        check("ped_pend_set", 32'(bus_a.ped_pend), 32'd1);
        wait_a(3, 50, "ped_wait_walk");
        check("ped_pend_cleared", 32'(bus_a.ped_pend), 32'd0);

        // Request arriving exactly on the yellow-expiry cycle.
        wait_a(2, 60, "late_wait_yellow");
        step_n(1);
        bus_a.ped_req = 1'b1;
        step_n(1);
        bus_a.ped_req = 1'b0;
        check("late_ped_all", 32'(bus_a.ped_all), 32'd1);
        check("late_ped_pend", 32'(bus_a.ped_pend), 32'd0);

        // Slow tick: green spans three ticks of three clocks each.
        @(negedge clk) tick_div = 3;
        wait_a(1, 200, "slow_wait_not_green");
        wait_a(0, 200, "slow_wait_green");
        n_green = 0;
        while (a_cond(0) && n_green < 100) begin
            n_green++;
            step_n(1);
        end
        check("slow_green_clks", 32'(n_green), 32'd9);

        // Asynchronous reset in the middle of a green.
        wait_a(0, 200, "rst_wait_green");
        step_n(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_a_light", 32'(bus_a.light), 32'h09);
        check("async_rst_b_light", 32'(bus_b.light), 32'h249);
        @(negedge clk) tick_div = 1;
        @(negedge clk) rst = 1'b0;
        step_n(1);
        check("restart_a_ped_all", 32'(bus_a.ped_all), 32'd1);
        check("restart_b_ped_all", 32'(bus_b.ped_all), 32'd1);
        step_n(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
